add4_stimulus_checker: RTL and testbench

//  Drives one {ci,a,b} vector at a time onto the 4-bit ripple adder inputs,

---
 rtl/add4_chk_pkg.sv | 25 ++
 rtl/add4_stimulus_checker_sat_counter.sv | 23 ++
 rtl/add4_stimulus_checker.sv | 137 +++++++++++++
 tb/tb_add4_stimulus_checker.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add4_chk_pkg.sv
// Shared types and the reference arithmetic for the 4-bit adder stimulus checker.
// The checker's state encoding and expected-result function live here.
package add4_chk_pkg;

    localparam int ADD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } chk_state_e;

    // Full-width result of a + b + ci; the extra bit keeps the carry so nothing is truncated.
    function automatic logic [ADD_W:0] exp_sum(input logic [2*ADD_W:0] vec);
        logic [ADD_W:0] a_s;
        logic [ADD_W:0] b_s;
        logic [ADD_W:0] ci_s;
        a_s  = {1'b0, vec[2*ADD_W-1:ADD_W]};
        b_s  = {1'b0, vec[ADD_W-1:0]};
        ci_s = {{ADD_W{1'b0}}, vec[2*ADD_W]};
        return a_s + b_s + ci_s;
    endfunction

endpackage

// File: rtl/add4_stimulus_checker_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count increments, clamped at the maximum value
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= {CNT_W{1'b0}};
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/add4_stimulus_checker.sv
// Drives one {ci,a,b} vector at a time to a ripple adder, waits a fixed settle
// time, then checks {co,sum} against a + b + ci and keeps pass/fail statistics.
module add4_stimulus_checker
    import add4_chk_pkg::*;
#(
    parameter int WIDTH         = ADD_W,
    parameter int SETTLE_CYCLES = 3,
    parameter int CNT_W         = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stim_valid,
    output logic               stim_ready,
    input  logic [2*WIDTH:0]   stim_vec,
    input  logic               stim_last,
    output logic [2*WIDTH:0]   stim_out,
    input  logic [WIDTH-1:0]   dut_sum,
    input  logic               dut_co,
    output logic               mismatch,
    output logic [CNT_W-1:0]   pass_count,
    output logic [CNT_W-1:0]   fail_count,
    output logic [2*WIDTH:0]   first_fail_vec,
    output logic               first_fail_valid,
    output logic               done
);

    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);

    chk_state_e       state_r;
    chk_state_e       state_nxt_s;
    logic [SC_W-1:0]  settle_cnt_r;
    logic             last_r;
    logic             accept_s;
    logic             compare_s;
    logic             match_s;
    logic             pass_inc_s;
    logic             fail_inc_s;

    // Handshake, compare qualification and the result check
    always_comb begin
        accept_s   = stim_valid && stim_ready && (state_r == ST_IDLE);
        compare_s  = (state_r == ST_COMPARE);
        // Case equality so any X/Z on the adder outputs is treated as a failure
        match_s    = ({dut_co, dut_sum} === exp_sum(stim_out));
        pass_inc_s = compare_s && match_s;
        fail_inc_s = compare_s && !match_s;
    end

    // Next-state selection for the vector sequencing FSM
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_SETTLE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_r == {SC_W{1'b0}}) begin
                    state_nxt_s = ST_COMPARE;
                end else begin
                    state_nxt_s = ST_SETTLE;
                end
            end
            ST_COMPARE: begin
                if (last_r) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_DONE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, vector launch, settle timing and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= ST_IDLE;
            settle_cnt_r     <= {SC_W{1'b0}};
            last_r           <= 1'b0;
            stim_out         <= {(2*WIDTH+1){1'b0}};
            stim_ready       <= 1'b0;
            mismatch         <= 1'b0;
            done             <= 1'b0;
            first_fail_vec   <= {(2*WIDTH+1){1'b0}};
            first_fail_valid <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            stim_ready <= (state_nxt_s == ST_IDLE);
            done       <= (state_nxt_s == ST_DONE);
            mismatch   <= fail_inc_s;

            // stim_out only moves on accept, so the adder sees a stable vector throughout settle
            if (accept_s) begin
                stim_out     <= stim_vec;
                last_r       <= stim_last;
                settle_cnt_r <= SETTLE_LOAD;
            end else if ((state_r == ST_SETTLE) && (settle_cnt_r != {SC_W{1'b0}})) begin
                settle_cnt_r <= settle_cnt_r - {{(SC_W-1){1'b0}}, 1'b1};
            end else begin
                settle_cnt_r <= settle_cnt_r;
            end

            if (fail_inc_s && !first_fail_valid) begin
                first_fail_vec   <= stim_out;
                first_fail_valid <= 1'b1;
            end else begin
                first_fail_vec   <= first_fail_vec;
                first_fail_valid <= first_fail_valid;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (pass_inc_s),
        .count (pass_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (fail_inc_s),
        .count (fail_count)
    );

endmodule

// File: tb/tb_add4_stimulus_checker.sv
// Self-checking bench: a behavioural 4-bit adder with fault injection is fed by
// the checker; a plain-arithmetic model predicts counts, pulses and first-fail capture.
module tb_add4_stimulus_checker;

    localparam int S     = 3;
    localparam int CW    = 16;
    localparam int SAT_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             stim_valid = 1'b0;
    logic             stim_last = 1'b0;
    logic [8:0]       stim_vec = 9'd0;
    logic             stim_ready;
    logic [8:0]       stim_out;
    logic [3:0]       dut_sum;
    logic             dut_co;
    logic             mismatch;
    logic [CW-1:0]    pass_count;
    logic [CW-1:0]    fail_count;
    logic [8:0]       first_fail_vec;
    logic             first_fail_valid;
    logic             done;

    logic             sat_ready;
    logic [8:0]       sat_out;
    logic             sat_mismatch;
    logic [SAT_W-1:0] sat_pass;
    logic [SAT_W-1:0] sat_fail;
    logic [8:0]       sat_ffv;
    logic             sat_ffvalid;
    logic             sat_done;

    logic             force_co0 = 1'b0;
    logic [4:0]       fault_mask = 5'd0;
    logic [4:0]       add_s;

    int exp_pass;
    int exp_fail;
    logic [8:0] exp_ff_vec;
    logic       exp_ff_valid;
    int n_vec   = 0;
    int n_check = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Adder under test, with optional carry stuck-at-0 and output bit flips
    assign add_s   = 5'(int'(stim_out[7:4]) + int'(stim_out[3:0]) + int'(stim_out[8]));
    assign dut_sum = add_s[3:0] ^ fault_mask[3:0];
    assign dut_co  = force_co0 ? 1'b0 : (add_s[4] ^ fault_mask[4]);

    add4_stimulus_checker #(.WIDTH(4), .SETTLE_CYCLES(S), .CNT_W(CW)) u_dut (
        .clk(clk), .rst(rst), .stim_valid(stim_valid), .stim_ready(stim_ready),
        .stim_vec(stim_vec), .stim_last(stim_last), .stim_out(stim_out),
        .dut_sum(dut_sum), .dut_co(dut_co), .mismatch(mismatch),
        .pass_count(pass_count), .fail_count(fail_count),
        .first_fail_vec(first_fail_vec), .first_fail_valid(first_fail_valid), .done(done)
    );

    // Narrow-counter copy sharing the same stimulus, used to observe saturation
    add4_stimulus_checker #(.WIDTH(4), .SETTLE_CYCLES(S), .CNT_W(SAT_W)) u_sat (
        .clk(clk), .rst(rst), .stim_valid(stim_valid), .stim_ready(sat_ready),
        .stim_vec(stim_vec), .stim_last(stim_last), .stim_out(sat_out),
        .dut_sum(dut_sum), .dut_co(dut_co), .mismatch(sat_mismatch),
        .pass_count(sat_pass), .fail_count(sat_fail),
        .first_fail_vec(sat_ffv), .first_fail_valid(sat_ffvalid), .done(sat_done)
    );

    function automatic int sat7(input int v);
        return (v > 7) ? 7 : v;
    endfunction

    task automatic do_reset(input int cyc);
        @(negedge clk);
        rst = 1'b1;
        stim_valid = 1'b0;
        force_co0 = 1'b0;
        fault_mask = 5'd0;
        repeat (cyc) @(negedge clk);
        rst = 1'b0;
        exp_pass = 0;
        exp_fail = 0;
        exp_ff_vec = 9'd0;
        exp_ff_valid = 1'b0;
    endtask

    // Offer one vector, wait for its compare, and check everything the model predicts
    task automatic apply_vec(input logic [8:0] v, input logic last, input logic co0,
                             input logic [4:0] mask);
        int n;
        int lat;
        int correct;
        logic [4:0] observed;
        logic exp_mm;
        n = 0;
        while (stim_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_check++;
        if (n >= 100) begin
            n_fail++;
            $display("FAIL ready_timeout: stim_ready=%b required 1", stim_ready);
        end
        force_co0 = co0;
        fault_mask = mask;
        stim_vec = v;
        stim_last = last;
        stim_valid = 1'b1;
        @(posedge clk);
        #1;
        stim_valid = 1'b0;
        stim_last = 1'b0;
        stim_vec = 9'($urandom);
        n_vec++;
        n_check++;
        if (stim_out !== v) begin
            n_fail++;
            $display("FAIL stim_out_launch: got %b required %b", stim_out, v);
        end

        correct = int'(v[7:4]) + int'(v[3:0]) + int'(v[8]);
        observed = 5'(correct) ^ mask;
        if (co0) observed[4] = 1'b0;
        exp_mm = (int'(observed) != correct);

        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (pass_count !== CW'(exp_pass) || fail_count !== CW'(exp_fail)) begin
                lat = k;
                break;
            end
        end
        n_check++;
        if (lat != S + 1) begin
            n_fail++;
            $display("FAIL latency: vec=%b got %0d cycles required %0d", v, lat, S + 1);
        end

        if (exp_mm) begin
            exp_fail++;
            if (!exp_ff_valid) begin
                exp_ff_valid = 1'b1;
                exp_ff_vec = v;
            end
        end else begin
            exp_pass++;
        end

        n_check++;
        if (pass_count !== CW'(exp_pass) || fail_count !== CW'(exp_fail)) begin
            n_fail++;
            $display("FAIL counts: vec=%b pass=%0d fail=%0d required pass=%0d fail=%0d",
                     v, pass_count, fail_count, exp_pass, exp_fail);
        end
        n_check++;
        if (mismatch !== exp_mm) begin
            n_fail++;
            $display("FAIL mismatch_pulse: vec=%b got %b required %b", v, mismatch, exp_mm);
        end
        n_check++;
        if (first_fail_valid !== exp_ff_valid || first_fail_vec !== exp_ff_vec) begin
            n_fail++;
            $display("FAIL first_fail: got valid=%b vec=%b required valid=%b vec=%b",
                     first_fail_valid, first_fail_vec, exp_ff_valid, exp_ff_vec);
        end
        n_check++;
        if (stim_out !== v) begin
            n_fail++;
            $display("FAIL stim_out_hold: got %b required %b", stim_out, v);
        end
        force_co0 = 1'b0;
        fault_mask = 5'd0;

        @(posedge clk);
        #1;
        n_check++;
        if (mismatch !== 1'b0) begin
            n_fail++;
            $display("FAIL mismatch_width: got %b required 0 one cycle after compare", mismatch);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        stim_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_check++;
        if ({stim_ready, stim_out, mismatch, pass_count, fail_count, first_fail_vec,
             first_fail_valid, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b out=%b mm=%b pass=%0d fail=%0d ffv=%b ffval=%b done=%b required all 0",
                     stim_ready, stim_out, mismatch, pass_count, fail_count, first_fail_vec,
                     first_fail_valid, done);
        end
        rst = 1'b0;
        exp_pass = 0;
        exp_fail = 0;
        exp_ff_vec = 9'd0;
        exp_ff_valid = 1'b0;
        @(posedge clk);
        #1;
        n_check++;
        if (stim_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b done=%b required ready=1 done=0", stim_ready, done);
        end
    endtask

    task automatic test_single();
        apply_vec(9'b0_0011_0101, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic test_overflow();
        apply_vec(9'b1_1111_1111, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic test_fault();
        apply_vec(9'b0_1000_1000, 1'b0, 1'b1, 5'd0);
        n_check++;
        if (first_fail_vec !== 9'b0_1000_1000 || fail_count !== 16'd1) begin
            n_fail++;
            $display("FAIL fault_capture: ffv=%b fail=%0d required ffv=010001000 fail=1",
                     first_fail_vec, fail_count);
        end
        apply_vec(9'b0_0001_0001, 1'b0, 1'b0, 5'b00001);
    endtask

    task automatic test_random();
        logic [4:0] mask;
        for (int i = 0; i < 40; i++) begin
            mask = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            apply_vec(9'($urandom), 1'b0, 1'b0, mask);
        end
        n_check++;
        if (sat_pass !== SAT_W'(sat7(exp_pass)) || sat_fail !== SAT_W'(sat7(exp_fail))) begin
            n_fail++;
            $display("FAIL saturation_mixed: pass=%0d fail=%0d required pass=%0d fail=%0d",
                     sat_pass, sat_fail, sat7(exp_pass), sat7(exp_fail));
        end
    endtask

    task automatic test_idle_hold();
        logic [8:0] held;
        held = stim_out;
        repeat (5) begin
            @(negedge clk);
            stim_vec = 9'($urandom);
        end
        #1;
        n_check++;
        if (stim_ready !== 1'b1 || stim_out !== held ||
            pass_count !== CW'(exp_pass) || fail_count !== CW'(exp_fail)) begin
            n_fail++;
            $display("FAIL idle_hold: ready=%b out=%b pass=%0d fail=%0d required ready=1 out=%b pass=%0d fail=%0d",
                     stim_ready, stim_out, pass_count, fail_count, held, exp_pass, exp_fail);
        end
    endtask

    task automatic test_reset_in_settle();
        int bad;
        do_reset(2);
        @(posedge clk);
        #1;
        fault_mask = 5'b00100;
        stim_vec = 9'b0_0110_0011;
        stim_valid = 1'b1;
        @(posedge clk);
        #1;
        stim_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < S + 3; k++) begin
            @(posedge clk);
            #1;
            if (mismatch !== 1'b0 || pass_count !== 16'd0 || fail_count !== 16'd0) bad++;
        end
        fault_mask = 5'd0;
        n_check++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_in_settle: %0d cycles with count or pulse activity required 0", bad);
        end
        n_check++;
        if (stim_ready !== 1'b1 || done !== 1'b0 || first_fail_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_settle_state: ready=%b done=%b ffval=%b required 1 0 0",
                     stim_ready, done, first_fail_valid);
        end
    endtask

    task automatic test_exhaustive();
        logic [8:0] order[512];
        logic [8:0] tmp;
        int j;
        do_reset(2);
        for (int i = 0; i < 512; i++) order[i] = 9'(i);
        for (int i = 511; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        for (int i = 0; i < 512; i++) begin
            if ($urandom_range(0, 7) == 0) @(negedge clk);
            apply_vec(order[i], (i == 511), 1'b0, 5'd0);
        end
        stim_valid = 1'b1;
        stim_vec = 9'd1;
        repeat (6) @(posedge clk);
        #1;
        stim_valid = 1'b0;
        n_check++;
        if (done !== 1'b1 || stim_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL done_hold: done=%b ready=%b required done=1 ready=0", done, stim_ready);
        end
        n_check++;
        if (pass_count !== 16'd512 || fail_count !== 16'd0) begin
            n_fail++;
            $display("FAIL exhaustive_counts: pass=%0d fail=%0d required 512 0", pass_count, fail_count);
        end
        n_check++;
        if (sat_pass !== 3'b111 || sat_fail !== 3'd0 || sat_done !== 1'b1) begin
            n_fail++;
            $display("FAIL saturation: pass=%0d fail=%0d done=%b required 7 0 1", sat_pass, sat_fail, sat_done);
        end
    endtask

    initial begin
        exp_pass = 0;
        exp_fail = 0;
        exp_ff_vec = 9'd0;
        exp_ff_valid = 1'b0;
        test_reset();
        test_single();
        test_overflow();
        test_fault();
        test_random();
        test_idle_hold();
        test_reset_in_settle();
        test_exhaustive();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
